// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer and its decoder.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [2:0] {
    C_ILL, C_R, C_I, C_LOAD, C_STORE, C_BRANCH
  } cls_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  localparam logic [4:0] ALU_NOP  = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00011;
  localparam logic [4:0] ALU_SUB  = 5'b00100;
  localparam logic [4:0] ALU_SLL  = 5'b00101;
  localparam logic [4:0] ALU_SLT  = 5'b00110;
  localparam logic [4:0] ALU_SLTU = 5'b00111;
  localparam logic [4:0] ALU_XOR  = 5'b01000;
  localparam logic [4:0] ALU_SRL  = 5'b01001;
  localparam logic [4:0] ALU_SRA  = 5'b01010;
  localparam logic [4:0] ALU_OR   = 5'b01011;
  localparam logic [4:0] ALU_AND  = 5'b01100;

  localparam logic [2:0] EXT_NONE = 3'b000;
  localparam logic [2:0] EXT_S    = 3'b001;
  localparam logic [2:0] EXT_I    = 3'b010;
  localparam logic [2:0] EXT_B    = 3'b100;

  localparam logic [2:0] NPC_PC4  = 3'b000;
  localparam logic [2:0] NPC_BR   = 3'b001;

  localparam logic [2:0] DM_W     = 3'b000;
  localparam logic [2:0] DM_H     = 3'b001;
  localparam logic [2:0] DM_HU    = 3'b010;
  localparam logic [2:0] DM_B     = 3'b011;
  localparam logic [2:0] DM_BU    = 3'b100;

  localparam logic [1:0] WD_ALU   = 2'b00;
  localparam logic [1:0] WD_MEM   = 2'b01;

  // ALU operation for R / I-ALU; alt selects sub/sra on the shared funct3 slots
  function automatic logic [4:0] alu_code(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Data-memory access type from load/store funct3
  function automatic logic [2:0] dm_code(input logic [2:0] f3);
    case (f3)
      3'b000:  return DM_B;
      3'b001:  return DM_H;
      3'b100:  return DM_BU;
      3'b101:  return DM_HU;
      default: return DM_W;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: class, ALU/ext/mem selects, illegal flag.
module mc_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output cls_t       cls,
  output logic [4:0] alu_op,
  output logic [2:0] ext_op,
  output logic [2:0] dm_type,
  output logic       illegal
);

  logic alt;
  logic shamt_ok;

  assign alt     = (funct7 == F7_ALT);
  assign illegal = (cls == C_ILL);

  // Classify by opcode; any encoding not listed stays C_ILL
  always_comb begin
    cls      = C_ILL;
    alu_op   = ALU_NOP;
    ext_op   = EXT_NONE;
    dm_type  = DM_W;
    // only shifts constrain funct7 in I-ALU; elsewhere it is immediate bits
    shamt_ok = (funct3 == 3'b001) ? (funct7 == 7'b0) :
               (funct3 == 3'b101) ? (funct7 == 7'b0 || alt) : 1'b1;
    case (op)
      OP_R: if (funct7 == 7'b0 || (alt && (funct3 == 3'b000 || funct3 == 3'b101))) begin
        cls    = C_R;
        alu_op = alu_code(funct3, alt);
      end
      OP_I: if (shamt_ok) begin
        cls    = C_I;
        alu_op = alu_code(funct3, funct3 == 3'b101 && alt);
        ext_op = EXT_I;
      end
      OP_LOAD: if (funct3 != 3'b011 && funct3[2:1] != 2'b11) begin
        cls     = C_LOAD;
        alu_op  = ALU_ADD;
        ext_op  = EXT_I;
        dm_type = dm_code(funct3);
      end
      OP_STORE: if (!funct3[2] && funct3[1:0] != 2'b11) begin
        cls     = C_STORE;
        alu_op  = ALU_ADD;
        ext_op  = EXT_S;
        dm_type = dm_code(funct3);
      end
      OP_BRANCH: if (funct3[2:1] == 2'b00) begin
        cls    = C_BRANCH;
        alu_op = ALU_SUB;
        ext_op = EXT_B;
      end
      default: cls = C_ILL;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I sequencer: FSM, shared memory-port handshake, retire counter.
module mc_ctrl
  import ctrl_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [6:0]          Op,
  input  logic [2:0]          Funct3,
  input  logic [6:0]          Funct7,
  input  logic                Zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                MemWrite,
  output logic                PCWrite,
  output logic                IRWrite,
  output logic                RegWrite,
  output logic                ALUSrc,
  output logic [4:0]          ALUOp,
  output logic [2:0]          EXTOp,
  output logic [2:0]          NPCOp,
  output logic [2:0]          DMType,
  output logic [1:0]          WDSel,
  output logic                halted,
  output logic [RETIRE_W-1:0] retired
);

  state_t     state;
  // low through reset and the release cycle so FETCH does not request early
  logic       run;
  cls_t       cls;
  logic [4:0] dec_alu;
  logic [2:0] dec_ext;
  logic [2:0] dec_dm;
  logic       illegal;
  logic       fetch_go;
  logic       mem_go;
  logic       taken;
  logic       retire;

  mc_decode u_decode (
    .op      (Op),
    .funct3  (Funct3),
    .funct7  (Funct7),
    .cls     (cls),
    .alu_op  (dec_alu),
    .ext_op  (dec_ext),
    .dm_type (dec_dm),
    .illegal (illegal)
  );

  // Strobes decode from state and class; mem_ready/Zero are the only same-cycle inputs
  always_comb begin
    fetch_go = run && (state == S_FETCH) && mem_ready;
    mem_go   = (state == S_MEM) && mem_ready;
    taken    = (cls == C_BRANCH) && (Funct3[0] ? !Zero : Zero);
    retire   = ((state == S_EXEC) && (cls == C_BRANCH)) ||
               (mem_go && (cls == C_STORE)) || (state == S_WB);
    mem_req  = (run && state == S_FETCH) || (state == S_MEM);
    MemWrite = (state == S_MEM) && (cls == C_STORE);
    IRWrite  = fetch_go;
    PCWrite  = fetch_go || ((state == S_EXEC) && taken);
    RegWrite = (state == S_WB);
    ALUSrc   = (state == S_EXEC) && (cls == C_I || cls == C_LOAD || cls == C_STORE);
    ALUOp    = (state == S_EXEC) ? dec_alu : ALU_NOP;
    EXTOp    = (state == S_EXEC) ? dec_ext : EXT_NONE;
    NPCOp    = ((state == S_EXEC) && taken) ? NPC_BR : NPC_PC4;
    DMType   = (state == S_MEM) ? dec_dm : DM_W;
    WDSel    = ((state == S_WB) && (cls == C_LOAD)) ? WD_MEM : WD_ALU;
    halted   = (state == S_HALT);
  end

  // Sequencer state and retired-instruction counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_FETCH;
      run     <= 1'b0;
      retired <= '0;
    end else begin
      run <= 1'b1;
      if (retire) retired <= retired + RETIRE_W'(1);
      case (state)
        S_FETCH:  if (fetch_go) state <= S_DECODE;
        S_DECODE: state <= illegal ? S_HALT : S_EXEC;
        S_EXEC: begin
          case (cls)
            C_R, C_I:        state <= S_WB;
            C_LOAD, C_STORE: state <= S_MEM;
            default:         state <= S_FETCH;
          endcase
        end
        S_MEM:    if (mem_go) state <= (cls == C_STORE) ? S_FETCH : S_WB;
        S_WB:     state <= S_FETCH;
        default:  state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: per-cycle expected strobes from an instruction-phase model.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [6:0]  Op = '0;
  logic [2:0]  Funct3 = '0;
  logic [6:0]  Funct7 = '0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, MemWrite, PCWrite, IRWrite, RegWrite, ALUSrc, halted;
  logic [4:0]  ALUOp;
  logic [2:0]  EXTOp, NPCOp, DMType;
  logic [1:0]  WDSel;
  logic [31:0] retired;

  mc_ctrl #(.RETIRE_W(32)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct3(Funct3), .Funct7(Funct7), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .EXTOp(EXTOp),
    .NPCOp(NPCOp), .DMType(DMType), .WDSel(WDSel), .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_req, MemWrite, PCWrite, IRWrite, RegWrite, ALUSrc;
    logic [4:0]  ALUOp;
    logic [2:0]  EXTOp, NPCOp, DMType;
    logic [1:0]  WDSel;
    logic        halted;
    logic [31:0] retired;
  } exp_t;

  typedef struct packed {
    logic       legal;
    logic [2:0] kind;
    logic [4:0] alu;
    logic [2:0] ext;
    logic [2:0] dm;
    logic       src;
  } dec_t;

  localparam logic [2:0] K_R = 3'd1, K_I = 3'd2, K_L = 3'd3, K_S = 3'd4, K_B = 3'd5;
  // add,sll,slt,sltu,xor,srl,or,and indexed by funct3
  localparam logic [4:0] ALU_TAB [8] = '{5'd3, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd11, 5'd12};
  // lb,lh,lw,-,lbu,lhu
  localparam logic [2:0] DM_TAB [8]  = '{3'd3, 3'd1, 3'd0, 3'd0, 3'd4, 3'd2, 3'd0, 3'd0};
  localparam logic [2:0] LD_F3 [5]   = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  exp_t        expq[$];
  logic [31:0] n_ret = '0;
  int          checks = 0;
  int          errors = 0;

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t cur();
    return '{mem_req, MemWrite, PCWrite, IRWrite, RegWrite, ALUSrc, ALUOp, EXTOp,
             NPCOp, DMType, WDSel, halted, retired};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference classification from the ISA tables
  function automatic dec_t ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    dec_t d = '0;
    case (op)
      7'h33: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
        d.legal = 1; d.kind = K_R;
        d.alu = (f7 == 7'h20) ? ((f3 == 3'd0) ? 5'd4 : 5'd10) : ALU_TAB[f3];
      end
      7'h13: if (!(f3 == 3'd1 && f7 != 0) && !(f3 == 3'd5 && f7 != 0 && f7 != 7'h20)) begin
        d.legal = 1; d.kind = K_I; d.ext = 3'd2; d.src = 1;
        d.alu = (f3 == 3'd5 && f7 == 7'h20) ? 5'd10 : ALU_TAB[f3];
      end
      7'h03: if (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) begin
        d.legal = 1; d.kind = K_L; d.alu = 5'd3; d.ext = 3'd2; d.src = 1; d.dm = DM_TAB[f3];
      end
      7'h23: if (f3 <= 3'd2) begin
        d.legal = 1; d.kind = K_S; d.alu = 5'd3; d.ext = 3'd1; d.src = 1; d.dm = DM_TAB[f3];
      end
      7'h63: if (f3 <= 3'd1) begin
        d.legal = 1; d.kind = K_B; d.alu = 5'd4; d.ext = 3'd4;
      end
      default: d.legal = 0;
    endcase
    return d;
  endfunction

  // Drive one cycle's inputs and queue what the DUT must show during that cycle
  task automatic step(input exp_t e, input logic rdy, input logic z, input logic ret);
    mem_ready = rdy;
    Zero      = z;
    e.retired = n_ret;
    expq.push_back(e);
    if (ret) n_ret = n_ret + 1;
    @(posedge clk); #1;
  endtask

  // One instruction as phases: fetch(+waits), decode, exec, mem(+waits), wb
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input int fw, input int mw, input bit zfix, input bit zval,
                           input int abort_mem);
    dec_t d;
    exp_t e;
    logic z, tk;
    d = ref_dec(op, f3, f7);
    Op = op; Funct3 = f3; Funct7 = f7;
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.mem_req = 1; e.PCWrite = (i == fw); e.IRWrite = (i == fw);
      step(e, i == fw, rb(), 0);
    end
    e = '0;
    step(e, rb(), rb(), 0);
    if (!d.legal) begin
      for (int i = 0; i < 20; i++) begin
        e = '0; e.halted = 1;
        step(e, rb(), rb(), 0);
      end
      return;
    end
    z  = zfix ? zval : rb();
    tk = (d.kind == K_B) && ((f3 == 3'd0) == z);
    e = '0; e.ALUSrc = d.src; e.ALUOp = d.alu; e.EXTOp = d.ext;
    if (tk) begin e.PCWrite = 1; e.NPCOp = 3'd1; end
    step(e, rb(), z, d.kind == K_B);
    if (d.kind == K_B) return;
    if (d.kind == K_L || d.kind == K_S) begin
      for (int i = 0; i <= mw; i++) begin
        if (i == abort_mem) return;
        e = '0; e.mem_req = 1; e.MemWrite = (d.kind == K_S); e.DMType = d.dm;
        step(e, i == mw, rb(), d.kind == K_S && i == mw);
      end
    end
    if (d.kind == K_S) return;
    e = '0; e.RegWrite = 1; e.WDSel = (d.kind == K_L) ? 2'd1 : 2'd0;
    step(e, rb(), rb(), 1);
  endtask

  task automatic do_reset(input string nm);
    rstn = 0; mem_ready = 0; n_ret = '0;
    #1;
    chk({nm, "_now"}, 64'(cur()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_hold"}, 64'(cur()), 64'd0);
    @(posedge clk); #1;
    rstn = 1;
    @(posedge clk); #1;
  endtask

  // Monitor: every queued cycle is compared against live outputs mid-cycle
  always @(negedge clk) begin
    if (expq.size() != 0) chk("cycle", 64'(cur()), 64'(expq.pop_front()));
  end

  initial begin
    #400000;
    $display("FAIL watchdog act=running req=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k;
    logic [2:0] f3;
    logic [6:0] f7, op;
    #2;
    do_reset("reset");
    run_instr(7'h33, 3'd0, 7'h00, 0, 0, 0, 0, -1);        // add x3,x1,x2
    chk("add_retired", 64'(retired), 64'd1);
    run_instr(7'h03, 3'd2, 7'h00, 2, 1, 0, 0, -1);        // lw, waits 2/1
    run_instr(7'h63, 3'd0, 7'h00, 0, 0, 1, 1, -1);        // beq taken
    run_instr(7'h63, 3'd0, 7'h00, 0, 0, 1, 0, -1);        // beq not taken
    run_instr(7'h63, 3'd1, 7'h00, 0, 0, 1, 0, -1);        // bne taken
    run_instr(7'h63, 3'd1, 7'h00, 0, 0, 1, 1, -1);        // bne not taken
    run_instr(7'h23, 3'd0, 7'h00, 0, 0, 0, 0, -1);        // sb
    chk("dir_retired", 64'(retired), 64'd7);
    for (int n = 0; n < 150; n++) begin
      k = int'($urandom_range(0, 4));
      f3 = 3'($urandom);
      f7 = '0;
      op = 7'h33;
      case (k)
        0: if ((f3 == 0 || f3 == 5) && rb()) f7 = 7'h20;
        1: begin
          op = 7'h13;
          if (f3 == 5) f7 = rb() ? 7'h20 : 7'h00;
          else if (f3 != 1) f7 = 7'($urandom);
        end
        2: begin op = 7'h03; f3 = LD_F3[$urandom_range(0, 4)]; end
        3: begin op = 7'h23; f3 = 3'($urandom_range(0, 2)); end
        default: begin op = 7'h63; f3 = 3'($urandom_range(0, 1)); end
      endcase
      run_instr(op, f3, f7, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 0, -1);
    end
    run_instr(7'h37, 3'd0, 7'h00, 1, 0, 0, 0, -1);        // lui: unsupported, halts
    chk("halt_retired", 64'(retired), 64'(n_ret));
    chk("halt_flag", 64'(halted), 64'd1);
    // reset while a load sits in MEM with memory stalled
    do_reset("reset2");
    run_instr(7'h13, 3'd4, 7'h55, 0, 0, 0, 0, -1);        // xori
    run_instr(7'h03, 3'd5, 7'h00, 1, 9, 0, 0, 2);         // lhu, abandoned mid-MEM
    do_reset("reset_mid_mem");
    run_instr(7'h33, 3'd5, 7'h20, 0, 0, 0, 0, -1);        // sra
    run_instr(7'h23, 3'd2, 7'h00, 1, 2, 0, 0, -1);        // sw with waits
    run_instr(7'h03, 3'd3, 7'h00, 0, 0, 0, 0, -1);        // load funct3 011: illegal
    chk("final_retired", 64'(retired), 64'd2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle sequencer for the RV32I core. It replaces the single-cycle decode-only control path with a Moore FSM that steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. Instruction and data accesses share one memory port using a req/ready handshake. The block drives the PC/IR write enables, the register-file and memory strobes, and ALU/extension/next-PC selects, and it counts retired instructions.

## Interface
- RETIRE_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- Op  in  7  opcode from IR; valid from DECODE onward
- Funct3  in  3  funct3 from IR
- Funct7  in  7  funct7 from IR
- Zero  in  1  ALU result == 0, valid in EXECUTE
- mem_ready  in  1  memory accepts/returns this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  request is a store (qualifies mem_req)
- PCWrite  out  1  PC load enable
- IRWrite  out  1  IR load enable
- RegWrite  out  1  register-file write enable
- ALUSrc  out  1  ALU B: 0=rs2, 1=immediate
- ALUOp  out  5  nop 00000, add 00011, sub 00100, plus the existing R/I codes
- EXTOp  out  3  imm type: I 010, S 001, B 100, none 000
- NPCOp  out  3  000=PC+4, 001=branch target
- DMType  out  3  word 000, half 001, half-u 010, byte 011, byte-u 100
- WDSel  out  2  00=ALU, 01=MEM
- halted  out  1  illegal instruction trapped
- retired  out  RETIRE_W  retired-instruction count

## Operation
- Supported classes: R-type (0110011), I-ALU (0010011), load (0000011), store (0100011), beq/bne (1100011, funct3 000/001). Any other opcode or funct3 encoding goes to HALT.
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- **FETCH**
  - mem_req=1, MemWrite=0; hold until mem_ready.
  - On the handshake cycle: IRWrite=1, PCWrite=1, NPCOp=000; go to DECODE.
- **DECODE**
  - One cycle, no strobes.
  - Classify the instruction; illegal goes to HALT, else to EXEC.
- **EXEC**
  - One cycle. ALUSrc, ALUOp and EXTOp are set by class. Load, store and I-ALU use ALUOp=add or the matching I-op.
  - Branch: ALUOp=sub. If taken (beq and Zero, or bne and !Zero), pulse PCWrite=1 with NPCOp=001. Branch retires here and goes to FETCH.
  - R and I-ALU go to WB. Load and store go to MEM.
- **MEM**
  - mem_req=1, MemWrite=1 for stores, DMType from funct3; hold until mem_ready.
  - Store retires on the handshake and goes to FETCH. Load goes to WB.
- **WB**
  - RegWrite=1 for one cycle; WDSel=01 for loads, else 00. Retire; go to FETCH.
- **HALT**
  - All strobes 0, halted=1. Absorbing state; only rstn leaves it.
- retired increments by 1 on each retire cycle and wraps modulo 2^RETIRE_W.
- Outputs decode from state, class and Zero. The only combinational input path is mem_ready/Zero to the strobes within the same cycle.

## Timing
- Reset (async assert): state=FETCH, retired=0, halted=0. Every strobe output is 0 while rstn=0; mem_req rises the first cycle after release.
- Reset mid-transaction: mem_req drops immediately and any partial access is abandoned. Memory must tolerate a dropped request.
- Handshake: mem_req and MemWrite/DMType stay stable until the cycle in which mem_ready=1. The transfer completes in that cycle, so zero-wait memory (mem_ready tied high) completes in one cycle. mem_ready while mem_req=0 is ignored.
- Zero-wait latency (cycles): R/I 4, load 5, store 4, branch 3. Each wait cycle adds 1 to FETCH or MEM.
- No overlap: the next FETCH starts the cycle after retire.
- The counter update takes effect at the edge ending the retire cycle.

## Structure
- Package ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ALUOp, EXTOp, NPCOp, DMType and WDSel encodings;
  - instruction-class enum.
- Sub-module mc_decode is combinational. It maps Op/Funct3/Funct7 to class, ALUOp, EXTOp, DMType and an illegal flag. mc_ctrl holds only the FSM, the handshake and the counter.

## Test plan
- add x3,x1,x2 with mem_ready=1: FETCH/DECODE/EXEC/WB in 4 cycles, RegWrite pulses once in cycle 4, ALUOp=00011, retired 0→1.
- lw with 2 wait states in FETCH and 1 in MEM: mem_req held 3 and 2 cycles respectively, DMType=000, WDSel=01, total 8 cycles.
- beq with Zero=1: PCWrite pulses in FETCH and in EXEC with NPCOp=001. With Zero=0, only the FETCH pulse occurs. Same pair for bne with inverted result.
- sb with mem_ready=1: MEM has mem_req=1, MemWrite=1, DMType=011; RegWrite never asserts; 4 cycles.
- Opcode 0110111: HALT after DECODE, halted=1, no further mem_req for 20 cycles, retired unchanged.
- rstn pulled low mid-MEM with mem_ready=0: mem_req drops the same cycle, retired=0. After release, FETCH re-issues mem_req.
